// File: rtl/usab_hc_axil_regs.sv
// AXI4-Lite slave register bank for the USAB 1.1 host controller.
// Word map (address bits [4:2]):
//   0..3 USER0..USER3 (RW, byte strobes), 4 STATUS (RO), 5 EVENT (sticky, W1C),
//   6 CMD (write-only strobe), 7 IRQ_EN (RW).
// Both address and data must be present before a write is accepted.
// READY is granted in the same cycle the inputs qualify, so the handshake
// and the commit happen in that one cycle.
module usab_hc_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     user_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     user_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     user_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     user_reg3,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_in,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     event_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cmd_pulse,
    output logic                              irq
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    localparam logic [2:0] WORD_STATUS = 3'd4;
    localparam logic [2:0] WORD_EVENT  = 3'd5;
    localparam logic [2:0] WORD_CMD    = 3'd6;
    localparam logic [2:0] WORD_IRQ_EN = 3'd7;

    // Register state
    logic [DW-1:0] user_reg [4];
    logic [DW-1:0] event_reg;
    logic [DW-1:0] event_next;
    logic [DW-1:0] irq_en_reg;
    logic [DW-1:0] cmd_pulse_reg;
    logic          irq_reg;

    // Channel state
    logic          bvalid_reg;
    logic          rvalid_reg;
    logic [DW-1:0] rdata_reg;

    // Decode helpers
    logic          wr_hs;
    logic          rd_hs;
    logic [2:0]    wr_word;
    logic [2:0]    rd_word;
    logic [DW-1:0] wstrb_mask;
    logic [DW-1:0] wr_masked;
    logic [DW-1:0] event_clear;
    logic [DW-1:0] rd_mux;

    // PROT and the byte-offset address bits carry no meaning for this block.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_word = S_AXI_AWADDR[4:2];
    assign rd_word = S_AXI_ARADDR[4:2];

    // A write is taken only with AW and W both present and no response pending.
    // Reset gates the grants so no beat is accepted while reset is held.
    assign wr_hs = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_reg & ~ARESET;
    assign rd_hs = S_AXI_ARVALID & ~rvalid_reg & ~ARESET;

    // Expand each byte strobe into an 8-bit lane mask.
    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_strb
            assign wstrb_mask[8*gi +: 8] = {8{S_AXI_WSTRB[gi]}};
        end
    endgenerate

    assign wr_masked = S_AXI_WDATA & wstrb_mask;

    // Clear mask for EVENT: only bits written as 1 in enabled byte lanes.
    assign event_clear = (wr_hs && wr_word == WORD_EVENT) ? wr_masked : '0;

    // A new event wins over a clear of the same bit in the same cycle.
    assign event_next = (event_reg & ~event_clear) | event_in;

    // Read multiplexer; CMD reads as zero, STATUS is the live input.
    always_comb begin
        rd_mux = '0;
        case (rd_word)
            3'd0, 3'd1, 3'd2, 3'd3: rd_mux = user_reg[rd_word[1:0]];
            WORD_STATUS:            rd_mux = status_in;
            WORD_EVENT:             rd_mux = event_reg;
            WORD_CMD:               rd_mux = '0;
            WORD_IRQ_EN:            rd_mux = irq_en_reg;
            default:                rd_mux = '0;
        endcase
    end

    // USER0..3: byte-masked merge of write data into the addressed word.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                user_reg[i] <= '0;
            end
        end else if (wr_hs && !wr_word[2]) begin
            user_reg[wr_word[1:0]] <= (user_reg[wr_word[1:0]] & ~wstrb_mask) | wr_masked;
        end
    end

    // IRQ_EN: byte-masked read/write word.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_en_reg <= '0;
        end else if (wr_hs && wr_word == WORD_IRQ_EN) begin
            irq_en_reg <= (irq_en_reg & ~wstrb_mask) | wr_masked;
        end
    end

    // EVENT: sticky bits set by the core, cleared by write-1.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            event_reg <= '0;
        end else begin
            event_reg <= event_next;
        end
    end

    // CMD strobe: one cycle of masked write data after the commit, zero otherwise.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_pulse_reg <= '0;
        end else if (wr_hs && wr_word == WORD_CMD) begin
            cmd_pulse_reg <= wr_masked;
        end else begin
            cmd_pulse_reg <= '0;
        end
    end

    // Interrupt: registered OR of enabled pending events.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |(event_reg & irq_en_reg);
        end
    end

    // Write response: raised after the handshake, held until the master takes it.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bvalid_reg <= 1'b0;
        end else if (wr_hs) begin
            bvalid_reg <= 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_reg <= 1'b0;
        end
    end

    // Read data: captured on the AR handshake (pre-write contents), held until RREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else if (rd_hs) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_mux;
        end else if (S_AXI_RREADY) begin
            rvalid_reg <= 1'b0;
        end
    end

    assign S_AXI_AWREADY = wr_hs;
    assign S_AXI_WREADY  = wr_hs;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_ARREADY = rd_hs;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_reg;

    assign user_reg0 = user_reg[0];
    assign user_reg1 = user_reg[1];
    assign user_reg2 = user_reg[2];
    assign user_reg3 = user_reg[3];
    assign cmd_pulse = cmd_pulse_reg;
    assign irq       = irq_reg;

endmodule

// File: tb/tb_usab_hc_axil_regs.sv
// Self-checking bench for usab_hc_axil_regs: a table of directed
// write/read vectors plus hand-written sequences for multi-cycle corners.
module tb_usab_hc_axil_regs;

    logic        clk;
    logic        srst;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] user_reg0, user_reg1, user_reg2, user_reg3;
    logic [31:0] status_in;
    logic [31:0] event_in;
    logic [31:0] cmd_pulse;
    logic        irq;

    int checks = 0;
    int errors = 0;

    usab_hc_axil_regs dut (
        .ACLK          (clk),
        .ARESET        (srst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .user_reg0     (user_reg0),
        .user_reg1     (user_reg1),
        .user_reg2     (user_reg2),
        .user_reg3     (user_reg3),
        .status_in     (status_in),
        .event_in      (event_in),
        .cmd_pulse     (cmd_pulse),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        @(posedge clk); #1;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!(awready && wready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("write_handshake");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("write_bvalid");
        check("bresp", {30'd0, bresp}, 32'd0);
        @(posedge clk); #1;
        bready = 1'b0;
        $display("write addr=0x%02h data=0x%08h strb=0x%h", a, d, s);
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        @(posedge clk); #1;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!arready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("read_handshake");
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout_fail("read_rvalid");
        d = rdata;
        check("rresp", {30'd0, rresp}, 32'd0);
        @(posedge clk); #1;
        rready = 1'b0;
        $display("read  addr=0x%02h data=0x%08h", a, d);
    endtask

    // CMD write observed cycle by cycle: pulse only in the cycle after the commit.
    task automatic cmd_seq(input logic [31:0] d, input logic [3:0] s, input logic [31:0] exp);
        @(posedge clk); #1;
        awaddr = 5'h18; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        @(negedge clk);
        check("cmd_hs", {31'd0, awready}, 32'd1);
        check("cmd_before", cmd_pulse, 32'd0);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("cmd_pulse", cmd_pulse, exp);
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("cmd_after", cmd_pulse, 32'd0);
        $display("cmd   data=0x%08h strb=0x%h pulse_exp=0x%08h", d, s, exp);
    endtask

    initial begin
        logic [31:0] rd;
        int n;

        srst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        status_in = 32'h1234_5678;
        event_in = '0;

        vecs[0]  = '{1'b1, 5'h00, 32'h0000_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 5'h04, 32'h0000_0002, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 5'h08, 32'h0000_0003, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 5'h0C, 32'h0000_0004, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 5'h00, 32'h0,         4'h0, 32'h0000_0001};
        vecs[5]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h0000_0002};
        vecs[6]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h0000_0003};
        vecs[7]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'h0000_0004};
        vecs[8]  = '{1'b1, 5'h04, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[9]  = '{1'b0, 5'h04, 32'h0,         4'h0, 32'h00BB_00DD};
        vecs[10] = '{1'b1, 5'h1C, 32'h0000_0010, 4'hF, 32'h0};
        vecs[11] = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0000_0010};
        vecs[12] = '{1'b1, 5'h10, 32'hFFFF_FFFF, 4'hF, 32'h0};
        vecs[13] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h1234_5678};
        vecs[14] = '{1'b0, 5'h18, 32'h0,         4'h0, 32'h0};
        vecs[15] = '{1'b0, 5'h02, 32'h0,         4'h0, 32'h0000_0001};

        repeat (3) @(posedge clk);
        #1 srst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,     32'd0);
        check("rst_cmd",     cmd_pulse, 32'd0);
        check("rst_irq",     {31'd0, irq}, 32'd0);
        check("rst_user0",   user_reg0, 32'd0);

        // Table-driven writes and reads
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_write) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            end else begin
                axi_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
            if (i == 3) begin
                check("user_reg0", user_reg0, 32'h1);
                check("user_reg1", user_reg1, 32'h2);
                check("user_reg2", user_reg2, 32'h3);
                check("user_reg3", user_reg3, 32'h4);
            end
        end

        // Event set -> irq, clear -> irq low
        @(posedge clk); #1 event_in = 32'h0000_0010;
        @(posedge clk); #1 event_in = 32'h0;
        @(negedge clk);
        check("irq_lag", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("irq_set", {31'd0, irq}, 32'd1);
        axi_read(5'h14, rd);
        check("event_set", rd, 32'h10);
        axi_write(5'h14, 32'h0000_0010, 4'hF);
        @(negedge clk);
        check("irq_clr", {31'd0, irq}, 32'd0);
        axi_read(5'h14, rd);
        check("event_clr", rd, 32'h0);

        // Clear concurrent with a new event on the same bit: bit survives
        @(posedge clk); #1;
        awaddr = 5'h14; wdata = 32'h10; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1; event_in = 32'h10;
        @(negedge clk);
        check("evt_conc_hs", {31'd0, awready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; event_in = 32'h0;
        @(posedge clk); #1 bready = 1'b0;
        axi_read(5'h14, rd);
        check("event_conc", rd, 32'h10);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);

        // CMD strobes
        cmd_seq(32'h0000_0081, 4'hF, 32'h0000_0081);
        cmd_seq(32'hFFFF_FFFF, 4'h2, 32'h0000_FF00);

        // Read and write of the same word in the same cycle returns old data
        @(posedge clk); #1;
        awaddr = 5'h08; wdata = 32'h0000_0099; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 5'h08; arvalid = 1'b1; rready = 1'b1;
        @(negedge clk);
        check("rw_same_hs", {30'd0, awready, arready}, 32'd3);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        check("rw_same_rdata", rdata, 32'h3);
        check("rw_same_user2", user_reg2, 32'h99);
        @(posedge clk); #1 bready = 1'b0; rready = 1'b0;
        $display("rw    addr=0x08 read_old=0x%08h new=0x%08h", rdata, user_reg2);

        // RDATA held while RREADY low; STATUS sampled at the AR handshake
        @(posedge clk); #1;
        status_in = 32'hA5A5_A5A5; araddr = 5'h10; arvalid = 1'b1; rready = 1'b0;
        @(negedge clk);
        check("stat_hs", {31'd0, arready}, 32'd1);
        @(posedge clk); #1 arvalid = 1'b0; status_in = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rhold%0d", k), {rvalid, rdata[30:0]}, {1'b1, 31'h25A5_A5A5});
            check($sformatf("rhold%0d_msb", k), {31'd0, rdata[31]}, 32'd1);
            @(posedge clk); #1;
        end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        @(negedge clk);
        check("rhold_done", {31'd0, rvalid}, 32'd0);
        $display("read  addr=0x10 held status=0xa5a5a5a5");

        // W three cycles before AW; BREADY held low; no second write accepted
        @(posedge clk); #1;
        awaddr = 5'h00; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("w_only%0d", k), {30'd0, awready, wready}, 32'd0);
            @(posedge clk); #1;
        end
        awvalid = 1'b1;
        @(negedge clk);
        check("w_late_hs", {30'd0, awready, wready}, 32'd3);
        @(posedge clk); #1;
        awaddr = 5'h04; wdata = 32'h0000_0055;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("b_hold%0d", k), {30'd0, bvalid, awready}, 32'd2);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("b_done", {31'd0, bvalid}, 32'd0);
        check("w_late_user0", user_reg0, 32'hDEAD_BEEF);
        check("w_late_user1", user_reg1, 32'h00BB_00DD);
        $display("write addr=0x00 data=0xdeadbeef (W before AW)");

        // Reset while BVALID is high abandons the response
        @(posedge clk); #1;
        awaddr = 5'h00; wdata = 32'h77; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge clk); #1 srst = 1'b1;
        @(posedge clk); #1 srst = 1'b0;
        @(negedge clk);
        check("post_rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("post_rst_user", user_reg0 | user_reg1 | user_reg2 | user_reg3, 32'd0);
        bready = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bvalid) n++;
        end
        check("no_late_b", n, 32'd0);
        bready = 1'b0;
        $display("reset mid-write: bvalid dropped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usab_hc_axil_regs.md
Name: usab_hc_axil_regs

Overview:
- AXI4-Lite slave register bank for the USAB 1.1 host-controller IP; it sits directly behind the IP's S00_AXI port and is driven by the AXI master.
- Provides four general read/write control words, a read-only status word and a sticky write-1-to-clear event word.
- Provides a write-only command strobe register and an interrupt-enable register that drives a registered interrupt line to the host-controller core and system.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; covers 8 words, 0x00–0x1C.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_AXI_AWADDR  in  5  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake.
- S_AXI_ARADDR  in  5  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00 (OKAY).
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake.
- user_reg0..user_reg3  out  32 each  contents of USER0..USER3.
- status_in  in  32  live core status.
- event_in  in  32  per-bit one-cycle event pulses from the core.
- cmd_pulse  out  32  one-cycle command strobes.
- irq  out  1  interrupt, registered.

Behaviour:
- Register map, address bits [4:2] select the word; bits [1:0] ignored:
  - 0x00–0x0C USER0–3: RW, byte-strobe honoured.
  - 0x10 STATUS: RO, returns status_in sampled on the AR handshake cycle; writes ignored.
  - 0x14 EVENT: sticky. Bit set by event_in; cleared by writing 1 with its byte strobe set.
  - 0x18 CMD: write drives cmd_pulse = WDATA masked by WSTRB for exactly one cycle, the cycle after the write commits; reads return 0.
  - 0x1C IRQ_EN: RW.
- Reset: all registers 0; all READY/VALID outputs 0; RDATA=0; cmd_pulse=0; irq=0. Reset mid-transaction abandons it; no B or R beat is issued afterwards.
- Write channel:
  - AWREADY and WREADY are each asserted for one cycle only when AWVALID and WVALID are both high and BVALID is low.
  - The write commits in that handshake cycle; register contents update on the following edge.
  - BVALID rises the cycle after the handshake and holds until BREADY.
  - One write outstanding at a time. AW-before-W and W-before-AW both wait with no acceptance.
- Read channel:
  - ARREADY is pulsed for one cycle when ARVALID is high and RVALID is low.
  - RDATA/RVALID are valid the next cycle. RDATA stays stable while RVALID is high and RREADY is low.
  - Read latency is 1 cycle from the handshake.
- Read and write channels are independent and may complete in the same cycle. A read of a word being written in the same handshake cycle returns the old value.
- EVENT next value = (EVENT & ~clear_mask) | event_in. A set and a clear of the same bit in the same cycle leaves the bit set.
- irq = |(EVENT & IRQ_EN), registered: one cycle behind the register state.
- cmd_pulse is 0 in every cycle except the single pulse cycle. Back-to-back CMD writes give pulses no closer than 2 cycles apart.

Test Plan:
- Writes 0x1,0x2,0x3,0x4 to 0x00/04/08/0C, all WSTRB=0xF, then read back -> data 0x1..0x4, RRESP=0, user_reg0..3 match.
- Write 0xAABBCCDD to USER1 with WSTRB=0x5 over prior 0x00000002 -> reads 0x00BB00DD.
- Pulse event_in=0x0000_0010, IRQ_EN=0x10 -> EVENT reads 0x10, irq=1. Write 0x10 to EVENT -> reads 0, irq=0 one cycle later. Clear concurrent with a new event_in bit4 pulse -> bit stays 1.
- Write 0x0000_0081 to CMD -> cmd_pulse=0x81 for exactly 1 cycle. A read of 0x18 returns 0.
- Present W 3 cycles before AW, and hold BREADY low 4 cycles -> no acceptance until AW arrives, BVALID held, no second write accepted.
- Assert ARESET while BVALID=1 -> BVALID=0, USER0..3=0, no later B beat.
